// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a req/ack instruction memory port,
// absorbs ctrl stalls with a one-entry buffer and applies ID redirects with a single bubble.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        be_i,
  input  logic [31:0] baddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {S_RESET, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] pend, pend_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] buf_inst, buf_inst_n;
  logic [31:0] id_pc_n, id_inst_n;
  logic        id_valid_n;
  logic        redirect;
  logic [31:0] target;

  assign redirect    = be_i && !stall_i;
  assign target      = {baddr_i[31:2], 2'b00};
  assign imem_req_o  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr_o = {fpc[31:2], 2'b00};

  // id_*_n is only consumed when not stalled; a bubble is the default delivery.
  always_comb begin
    state_n    = state;
    fpc_n      = fpc;
    pend_n     = pend;
    buf_pc_n   = buf_pc;
    buf_inst_n = buf_inst;
    id_pc_n    = 32'h0;
    id_inst_n  = NOP_INST;
    id_valid_n = 1'b0;
    case (state)
      S_RESET: state_n = S_REQ;
      S_REQ: begin
        if (redirect) begin
          if (imem_ack_i) begin
            fpc_n = target;
          end else begin
            pend_n  = target;
            state_n = S_DROP;
          end
        end else if (imem_ack_i) begin
          fpc_n = fpc + 32'd4;
          if (stall_i) begin
            buf_pc_n   = fpc;
            buf_inst_n = imem_rdata_i;
            state_n    = S_HOLD;
          end else begin
            id_pc_n    = fpc;
            id_inst_n  = imem_rdata_i;
            id_valid_n = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fpc_n   = target;
          state_n = S_REQ;
        end else if (!stall_i) begin
          id_pc_n    = buf_pc;
          id_inst_n  = buf_inst;
          id_valid_n = 1'b1;
          state_n    = S_REQ;
        end
      end
      S_DROP: begin
        // The address stays on the old fetch until ack; the newest redirect target wins.
        if (redirect) pend_n = target;
        if (imem_ack_i) begin
          fpc_n   = redirect ? target : pend;
          state_n = S_REQ;
        end
      end
      default: state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      fpc        <= RESET_PC;
      pend       <= RESET_PC;
      buf_pc     <= 32'h0;
      buf_inst   <= NOP_INST;
      id_pc_o    <= 32'h0;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else begin
      state    <= state_n;
      fpc      <= fpc_n;
      pend     <= pend_n;
      buf_pc   <= buf_pc_n;
      buf_inst <= buf_inst_n;
      if (!stall_i) begin
        id_pc_o    <= id_pc_n;
        id_inst_o  <= id_inst_n;
        id_valid_o <= id_valid_n;
      end
    end
  end

endmodule
